// File: rtl/id_tok_pkg.sv
// Shared defaults, token entry layout and saturating increment for id_token_stat.
package id_tok_pkg;

  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_DEPTH = 4;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] idx;
    logic [DEF_LEN_W-1:0] len;
  } tok_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tok_fifo.sv
// Synchronous FIFO with a registered head word (no fall-through) and
// wrap-bit pointers; a full FIFO accepts a push when the same edge pops.
module tok_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dout,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW:0]   r_wp, r_rp;
  logic [W-1:0]  r_head;
  logic [AW:0]   w_level, w_level_nxt, w_rp_nxt;
  logic          w_wr, w_rd;

  assign w_level     = r_wp - r_rp;
  assign o_full      = (w_level == (AW+1)'(DEPTH));
  assign o_empty     = (w_level == '0);
  assign w_rd        = i_pop & ~o_empty;
  assign w_wr        = i_push & (~o_full | w_rd);
  assign w_rp_nxt    = r_rp + {{AW{1'b0}}, w_rd};
  assign w_level_nxt = w_level + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};

  always_ff @(posedge clk) begin
    if (!i_clr && w_wr) r_mem[r_wp[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_head <= '0;
    end else if (i_clr) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_head <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      r_rp <= w_rp_nxt;
      // Head tracks the oldest entry; a push that becomes the only entry bypasses memory.
      if (w_level_nxt == '0)
        r_head <= '0;
      else if (w_wr && (o_empty || (w_rd && w_level == (AW+1)'(1))))
        r_head <= i_din;
      else if (w_rd)
        r_head <= r_mem[w_rp_nxt[AW-1:0]];
    end
  end

  assign o_dout  = r_head;
  assign o_level = w_level;

endmodule

// File: rtl/id_token_stat.sv
// Measures runs of the identifier-match flag and queues {idx,len} per token.
// Optional synchronous flush input enabled by macro ID_TOK_FLUSH_EN.
module id_token_stat
  import id_tok_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       match,
`ifdef ID_TOK_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       tok_ready,
  output logic                       tok_valid,
  output logic [CNT_W-1:0]           tok_idx,
  output logic [LEN_W-1:0]           tok_len,
  output logic [CNT_W-1:0]           tok_count,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam logic [31:0] RUN_MAX = 32'((1 << LEN_W) - 1);

  typedef struct packed {
    logic [CNT_W-1:0] idx;
    logic [LEN_W-1:0] len;
  } entry_t;

  logic              r_match_q;
  logic [LEN_W-1:0]  r_run;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              w_flush, w_done, w_full, w_empty;
  logic [LEN_W-1:0]  w_run_inc;
  entry_t            w_push_ent, w_head;

`ifdef ID_TOK_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Completion is the falling edge of the registered flag; a flush swallows it.
  assign w_done     = r_match_q & ~match & ~w_flush;
  assign w_run_inc  = LEN_W'(sat_inc(32'(r_run), RUN_MAX));
  assign w_push_ent = '{idx: r_count, len: r_run};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_q <= 1'b0;
      r_run     <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_flush) begin
        r_match_q <= 1'b0;
        r_run     <= '0;
      end else begin
        r_match_q <= match;
        r_run     <= match ? w_run_inc : '0;
      end
      if (w_done) r_count <= r_count + 1'b1;
      if (w_done && w_full && !tok_ready) r_ovf <= 1'b1;
    end
  end

  tok_fifo #(
    .W     (CNT_W + LEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_flush),
    .i_push  (w_done),
    .i_din   (w_push_ent),
    .i_pop   (tok_ready),
    .o_dout  (w_head),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign tok_valid = ~w_empty;
  assign tok_idx   = w_head.idx;
  assign tok_len   = w_head.len;
  assign tok_count = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_id_token_stat.sv
// Directed bench for id_token_stat with hand-computed expected values.
module tb_id_token_stat;

  logic        clk;
  logic        rst_n;
  logic        match;
  logic        tok_ready;
  logic        tok_valid;
  logic [15:0] tok_idx;
  logic [3:0]  tok_len;
  logic [15:0] tok_count;
  logic [2:0]  fifo_level;
  logic        overflow;
`ifdef ID_TOK_FLUSH_EN
  logic        flush;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  id_token_stat dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .match      (match),
`ifdef ID_TOK_FLUSH_EN
    .flush      (flush),
`endif
    .tok_ready  (tok_ready),
    .tok_valid  (tok_valid),
    .tok_idx    (tok_idx),
    .tok_len    (tok_len),
    .tok_count  (tok_count),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic cyc(input logic m, input logic r);
    match     = m;
    tok_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    match     = 1'b0;
    tok_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run2(input logic r_last);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, r_last);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(tok_valid), 0);
    chk({tag, "_idx"},   32'(tok_idx),   0);
    chk({tag, "_len"},   32'(tok_len),   0);
    chk({tag, "_cnt"},   32'(tok_count), 0);
    chk({tag, "_lvl"},   32'(fifo_level), 0);
    chk({tag, "_ovf"},   32'(overflow),  0);
  endtask

  initial begin
`ifdef ID_TOK_FLUSH_EN
    flush = 1'b0;
`endif
    do_reset();
    chk_zero("rst");

    // single run of 3 with consumer always ready
    cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b1);
    chk("t1_pre_valid", 32'(tok_valid), 0);
    cyc(1'b0, 1'b1);
    chk("t1_valid", 32'(tok_valid), 1);
    chk("t1_len",   32'(tok_len),   3);
    chk("t1_idx",   32'(tok_idx),   0);
    chk("t1_cnt",   32'(tok_count), 1);
    cyc(1'b0, 1'b1);
    chk("t1_drained", 32'(tok_valid), 0);

    // two 1-cycle runs separated by a 1-cycle gap
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("t2_lvl1", 32'(fifo_level), 1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("t2_lvl2", 32'(fifo_level), 2);
    chk("t2_idx0", 32'(tok_idx), 0);
    chk("t2_len0", 32'(tok_len), 1);
    chk("t2_cnt",  32'(tok_count), 2);
    chk("t2_ovf",  32'(overflow), 0);
    cyc(1'b0, 1'b1);
    chk("t2_idx1", 32'(tok_idx), 1);
    chk("t2_len1", 32'(tok_len), 1);
    cyc(1'b0, 1'b1);
    chk("t2_empty", 32'(tok_valid), 0);

    // 20-cycle run saturates at 15
    do_reset();
    repeat (20) cyc(1'b1, 1'b0);
    chk("t3_pre_valid", 32'(tok_valid), 0);
    cyc(1'b0, 1'b0);
    chk("t3_len", 32'(tok_len), 15);
    chk("t3_idx", 32'(tok_idx), 0);

    // five runs with no consumer: last one dropped
    do_reset();
    repeat (4) run2(1'b0);
    chk("t4_lvl4", 32'(fifo_level), 4);
    chk("t4_ovf0", 32'(overflow), 0);
    run2(1'b0);
    chk("t4_lvl", 32'(fifo_level), 4);
    chk("t4_ovf", 32'(overflow), 1);
    chk("t4_cnt", 32'(tok_count), 5);
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_idx", 32'(tok_idx), 32'(i));
      chk("t4_drain_len", 32'(tok_len), 2);
      cyc(1'b0, 1'b1);
    end
    chk("t4_empty", 32'(fifo_level), 0);
    chk("t4_ovf_sticky", 32'(overflow), 1);

    // full FIFO with a pop on the completion edge
    do_reset();
    repeat (4) run2(1'b0);
    run2(1'b1);
    chk("t5_lvl", 32'(fifo_level), 4);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_cnt", 32'(tok_count), 5);
    for (int i = 1; i < 5; i++) begin
      chk("t5_drain_idx", 32'(tok_idx), 32'(i));
      chk("t5_drain_len", 32'(tok_len), 2);
      cyc(1'b0, 1'b1);
    end
    chk("t5_empty", 32'(tok_valid), 0);

    // asynchronous reset mid-run with entries queued
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0);
    chk("t6_pre_lvl", 32'(fifo_level), 2);
    rst_n = 1'b0;
    match = 1'b0;
    #1;
    chk_zero("t6_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t6_no_emit", 32'(tok_valid), 0);
    cyc(1'b0, 1'b0);
    chk("t6_still_empty", 32'(tok_valid), 0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("t6_valid", 32'(tok_valid), 1);
    chk("t6_idx",   32'(tok_idx), 0);
    chk("t6_len",   32'(tok_len), 1);
    chk("t6_cnt",   32'(tok_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
